// File: rtl/multicast_tx_scheduler_pkg.sv
// rtl/multicast_tx_scheduler_pkg.sv - shared widths and FSM encoding for the multicast bus
package multicast_tx_scheduler_pkg;

  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int DEF_BITWIDTH      = 16;
  localparam int DEF_TABLE_DEPTH   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/multicast_tx_scheduler_if.sv
// rtl/multicast_tx_scheduler_if.sv - upstream word handshake plus multicast bus signals
interface multicast_tx_scheduler_if
  import multicast_tx_scheduler_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int BITWIDTH      = DEF_BITWIDTH
) ();

  logic                     in_valid;
  logic [BITWIDTH-1:0]      in_value;
  logic                     in_ready;
  logic                     bus_ready;
  logic                     tx_enable;
  logic [ADDRESS_WIDTH-1:0] tx_tag;
  logic [BITWIDTH-1:0]      tx_value;
  logic                     busy;
  logic                     word_done;

  modport master (
    input  in_valid, in_value, bus_ready,
    output in_ready, tx_enable, tx_tag, tx_value, busy, word_done
  );

  modport slave (
    output in_valid, in_value, bus_ready,
    input  in_ready, tx_enable, tx_tag, tx_value, busy, word_done
  );

endinterface

// File: rtl/multicast_tag_table.sv
// rtl/multicast_tag_table.sv - destination tag regfile, gated sync write, async read
module multicast_tag_table
  import multicast_tx_scheduler_pkg::*;
#(
  parameter int  ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int  TABLE_DEPTH   = DEF_TABLE_DEPTH,
  localparam int TABLE_AW      = $clog2(TABLE_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     i_we,
  input  logic [TABLE_AW-1:0]      i_waddr,
  input  logic [ADDRESS_WIDTH-1:0] i_wdata,
  input  logic [TABLE_AW-1:0]      i_raddr,
  output logic [ADDRESS_WIDTH-1:0] o_rdata
);

  logic [ADDRESS_WIDTH-1:0] r_tags [TABLE_DEPTH];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        r_tags[i] <= '0;
      end
    end else if (i_we) begin
      r_tags[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_tags[i_raddr];

endmodule

// File: rtl/multicast_tx_scheduler.sv
// rtl/multicast_tx_scheduler.sv - replays each upstream word once per active tag-table entry
module multicast_tx_scheduler
  import multicast_tx_scheduler_pkg::*;
#(
  parameter int  ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int  BITWIDTH      = DEF_BITWIDTH,
  parameter int  TABLE_DEPTH   = DEF_TABLE_DEPTH,
  localparam int TABLE_AW      = $clog2(TABLE_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     cfg_we,
  input  logic [TABLE_AW-1:0]      cfg_addr,
  input  logic [ADDRESS_WIDTH-1:0] cfg_tag,
  input  logic                     cfg_len_we,
  input  logic [TABLE_AW:0]        cfg_len,
  multicast_tx_scheduler_if.master bus
);

  localparam logic [TABLE_AW:0] LEN_MAX = (TABLE_AW + 1)'(TABLE_DEPTH);

  state_t                   r_state;
  logic [TABLE_AW-1:0]      r_idx;
  logic [TABLE_AW:0]        r_len;
  logic [BITWIDTH-1:0]      r_value;
  logic                     r_word_done;

  logic                     w_idle;
  logic                     w_send;
  logic                     w_tbl_we;
  logic                     w_len_we;
  logic [TABLE_AW:0]        w_len_clamped;
  logic [TABLE_AW:0]        w_len_eff;
  logic                     w_last;
  logic [ADDRESS_WIDTH-1:0] w_tag;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_send        = (r_state == ST_SEND);
  assign w_tbl_we      = cfg_we & w_idle;
  assign w_len_we      = cfg_len_we & w_idle;
  assign w_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  // A length written in the same cycle as an accepted word governs that word.
  assign w_len_eff     = w_len_we ? w_len_clamped : r_len;
  assign w_last        = ({1'b0, r_idx} == (r_len - (TABLE_AW + 1)'(1)));

  multicast_tag_table #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .TABLE_DEPTH   (TABLE_DEPTH)
  ) u_tag_table (
    .clk     (clk),
    .rstb    (rstb),
    .i_we    (w_tbl_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_tag),
    .i_raddr (r_idx),
    .o_rdata (w_tag)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_value     <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (w_len_we) begin
        r_len <= w_len_clamped;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (w_len_eff != '0) begin
              r_value <= bus.in_value;
              r_idx   <= '0;
              r_state <= ST_SEND;
            end else begin
              r_word_done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (bus.bus_ready) begin
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_idx       <= '0;
              r_word_done <= 1'b1;
            end else begin
              r_idx <= r_idx + TABLE_AW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_idle;
  assign bus.tx_enable = w_send;
  assign bus.tx_tag    = w_send ? w_tag : '0;
  assign bus.tx_value  = w_send ? r_value : '0;
  assign bus.busy      = ~w_idle;
  assign bus.word_done = r_word_done;

endmodule

// File: tb/tb_multicast_tx_scheduler.sv
// tb/tb_multicast_tx_scheduler.sv - scoreboard bench for the multicast transmit scheduler
module tb_multicast_tx_scheduler;
  import multicast_tx_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [3:0] cfg_tag = '0;
  logic       cfg_len_we = 1'b0;
  logic [3:0] cfg_len = '0;

  always #5 clk = ~clk;

  multicast_tx_scheduler_if bus_if ();

  multicast_tx_scheduler dut (
    .clk        (clk),
    .rstb       (rstb),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_tag    (cfg_tag),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
    .bus        (bus_if)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] value;
    bit          last;
  } xfer_t;

  xfer_t       exp_q[$];
  int          m_tab[8];
  int          m_len;
  int          checks = 0;
  int          errors = 0;
  int          nxfer = 0;
  int          ndone = 0;
  bit          mon_en = 1'b0;
  bit          done_due = 1'b0;
  bit          discard_flag = 1'b0;
  bit          prev_stall = 1'b0;
  bit          rand_br = 1'b0;
  logic [3:0]  prev_tag;
  logic [15:0] prev_val;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Monitor: pops one expected transfer per bus handshake and checks idle/stall rules.
  always @(negedge clk) begin
    if (!mon_en) begin
      done_due   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("word_done", bus_if.word_done, done_due | discard_flag);
      if (bus_if.word_done === 1'b1) ndone++;
      discard_flag = 1'b0;
      done_due     = 1'b0;
      if (bus_if.tx_enable !== 1'b1) begin
        check("idle_tx_value", bus_if.tx_value, 0);
        check("idle_tx_tag", bus_if.tx_tag, 0);
      end
      if (prev_stall) begin
        check("stall_enable", bus_if.tx_enable, 1);
        check("stall_tag", bus_if.tx_tag, prev_tag);
        check("stall_value", bus_if.tx_value, prev_val);
      end
      if (bus_if.tx_enable === 1'b1 && bus_if.bus_ready === 1'b1) begin
        nxfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          check("tx_tag", bus_if.tx_tag, e.tag);
          check("tx_value", bus_if.tx_value, e.value);
          done_due = e.last;
        end
      end
      prev_stall = (bus_if.tx_enable === 1'b1) && (bus_if.bus_ready !== 1'b1);
      prev_tag   = bus_if.tx_tag;
      prev_val   = bus_if.tx_value;
    end
  end

  always @(posedge clk) begin
    if (rand_br) begin
      #1;
      bus_if.bus_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_tab[i] = 0;
    m_len = 0;
    discard_flag = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic cfg_table(input int a, input int t, input bit apply);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_tag = 4'(t);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (apply) m_tab[a] = t;
  endtask

  task automatic cfg_length(input int l, input bit apply);
    cfg_len_we = 1'b1;
    cfg_len = 4'(l);
    @(posedge clk);
    #1;
    cfg_len_we = 1'b0;
    if (apply) m_len = (l > 8) ? 8 : l;
  endtask

  task automatic send_word(input logic [15:0] v);
    int t;
    t = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_value = v;
    @(negedge clk);
    while (bus_if.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("in_ready_timeout", bus_if.in_ready, 1);
    end else begin
      for (int i = 0; i < m_len; i++) begin
        exp_q.push_back('{tag: 4'(m_tab[i]), value: v, last: (i == m_len - 1)});
      end
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    if (m_len == 0 && t < 200) discard_flag = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 400) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus_if.busy === 1'b0 && !discard_flag && !done_due) break;
      t++;
    end
    if (t >= 400) check("idle_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int x0;
    int d0;
    bus_if.in_valid = 1'b0;
    bus_if.in_value = '0;
    bus_if.bus_ready = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_tx_enable", bus_if.tx_enable, 0);
    check("rst_busy", bus_if.busy, 0);
    @(posedge clk);
    #1;

    // Basic replay with latency check.
    cfg_table(0, 4, 1);
    cfg_table(1, 7, 1);
    cfg_table(2, 2, 1);
    cfg_length(3, 1);
    bus_if.bus_ready = 1'b1;
    send_word(16'hABCD);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus_if.word_done === 1'b1) break;
      n++;
    end
    check("word_done_latency", n, 3);
    check("in_ready_after_word", bus_if.in_ready, 1);
    @(posedge clk);
    #1;
    wait_idle();

    // Stall on second transfer.
    x0 = nxfer;
    send_word(16'hABCD);
    @(posedge clk);
    #1;
    bus_if.bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_if.bus_ready = 1'b1;
    wait_idle();
    check("stall_xfer_count", nxfer - x0, 3);

    // Zero length discards.
    cfg_length(0, 1);
    x0 = nxfer;
    d0 = ndone;
    send_word(16'h1234);
    wait_idle();
    check("len0_xfers", nxfer - x0, 0);
    check("len0_done_count", ndone - d0, 1);

    // Config writes during SEND are ignored.
    cfg_length(3, 1);
    send_word(16'h5555);
    cfg_table(1, 9, 0);
    cfg_length(1, 0);
    wait_idle();
    x0 = nxfer;
    send_word(16'h6666);
    wait_idle();
    check("cfg_ignored_xfers", nxfer - x0, 3);

    // Reset mid-SEND.
    send_word(16'h7777);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rstb = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_tab[i] = 0;
    m_len = 0;
    @(negedge clk);
    check("mid_rst_tx_enable", bus_if.tx_enable, 0);
    check("mid_rst_tx_tag", bus_if.tx_tag, 0);
    check("mid_rst_tx_value", bus_if.tx_value, 0);
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_word_done", bus_if.word_done, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    x0 = nxfer;
    send_word(16'h2222);
    wait_idle();
    check("post_rst_len0", nxfer - x0, 0);
    cfg_length(3, 1);
    send_word(16'h3333);
    wait_idle();

    // Back-to-back words, full table, random bus_ready.
    for (int i = 0; i < 8; i++) cfg_table(i, i, 1);
    cfg_length(8, 1);
    x0 = nxfer;
    rand_br = 1'b1;
    for (int w = 0; w < 4; w++) send_word(16'($urandom));
    wait_idle();
    rand_br = 1'b0;
    @(posedge clk);
    #1;
    bus_if.bus_ready = 1'b1;
    check("b2b_xfers", nxfer - x0, 32);

    // Oversized length clamps to table depth.
    for (int i = 0; i < 8; i++) cfg_table(i, 15 - i, 1);
    cfg_length(15, 1);
    x0 = nxfer;
    send_word(16'hC0DE);
    wait_idle();
    check("clamp_xfers", nxfer - x0, 8);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
